// File: rtl/id_ex_if.sv
// Bundle between the ID stage, the ID/EX register and the EX-side consumers:
// decoded ID fields in, registered EX fields, stall requests and perf counters out.
interface id_ex_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic            id_use_rs1;
  logic            id_use_rs2;
  logic [4:0]      id_rd;
  logic [1:0]      id_asel;
  logic [1:0]      id_bsel;
  logic [3:0]      id_alu_op;
  logic            id_mem_read;
  logic            id_mem_write;
  logic            id_reg_write;
  logic [1:0]      id_wb_sel;
  logic            flush;
  logic            ext_stall;

  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [XLEN-1:0] ex_imm;
  logic [4:0]      ex_rs1;
  logic [4:0]      ex_rs2;
  logic            ex_use_rs1;
  logic            ex_use_rs2;
  logic [4:0]      ex_rd;
  logic [1:0]      ex_asel;
  logic [1:0]      ex_bsel;
  logic [3:0]      ex_alu_op;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic            ex_reg_write;
  logic [1:0]      ex_wb_sel;
  logic            stall_pc;
  logic            stall_ifid;
  logic [CNT_W-1:0] perf_stall_cnt;
  logic [CNT_W-1:0] perf_flush_cnt;

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2,
           id_use_rs1, id_use_rs2, id_rd, id_asel, id_bsel, id_alu_op,
           id_mem_read, id_mem_write, id_reg_write, id_wb_sel, flush, ext_stall,
    input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2,
           ex_use_rs1, ex_use_rs2, ex_rd, ex_asel, ex_bsel, ex_alu_op,
           ex_mem_read, ex_mem_write, ex_reg_write, ex_wb_sel,
           stall_pc, stall_ifid, perf_stall_cnt, perf_flush_cnt
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2,
           id_use_rs1, id_use_rs2, id_rd, id_asel, id_bsel, id_alu_op,
           id_mem_read, id_mem_write, id_reg_write, id_wb_sel, flush, ext_stall,
    output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2,
           ex_use_rs1, ex_use_rs2, ex_rd, ex_asel, ex_bsel, ex_alu_op,
           ex_mem_read, ex_mem_write, ex_reg_write, ex_wb_sel,
           stall_pc, stall_ifid, perf_stall_cnt, perf_flush_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush and freeze.
// Optional saturating perf counters enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage (
  input  logic    clk,
  input  logic    rst,
  id_ex_if.slave  bus
);
  logic lu;
  logic bubble;

  assign lu = bus.ex_valid && bus.ex_mem_read && (bus.ex_rd != 5'd0) && bus.id_valid &&
              ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
               (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));

  assign bus.stall_pc   = (lu && !bus.flush) || bus.ext_stall;
  assign bus.stall_ifid = (lu && !bus.flush) || bus.ext_stall;

  // Flush beats a freeze; an empty ID slot is loaded as a bubble too.
  assign bubble = bus.flush || (!bus.ext_stall && (lu || !bus.id_valid));

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ex_valid     <= 1'b0;
      bus.ex_pc        <= '0;
      bus.ex_rs1_data  <= '0;
      bus.ex_rs2_data  <= '0;
      bus.ex_imm       <= '0;
      bus.ex_rs1       <= 5'd0;
      bus.ex_rs2       <= 5'd0;
      bus.ex_use_rs1   <= 1'b0;
      bus.ex_use_rs2   <= 1'b0;
      bus.ex_rd        <= 5'd0;
      bus.ex_asel      <= 2'd0;
      bus.ex_bsel      <= 2'd0;
      bus.ex_alu_op    <= 4'd0;
      bus.ex_mem_read  <= 1'b0;
      bus.ex_mem_write <= 1'b0;
      bus.ex_reg_write <= 1'b0;
      bus.ex_wb_sel    <= 2'd0;
    end else if (bubble) begin
      // Zero the indices so forwarding never matches; data fields hold.
      bus.ex_valid     <= 1'b0;
      bus.ex_mem_read  <= 1'b0;
      bus.ex_mem_write <= 1'b0;
      bus.ex_reg_write <= 1'b0;
      bus.ex_rd        <= 5'd0;
      bus.ex_rs1       <= 5'd0;
      bus.ex_rs2       <= 5'd0;
    end else if (!bus.ext_stall) begin
      bus.ex_valid     <= bus.id_valid;
      bus.ex_pc        <= bus.id_pc;
      bus.ex_rs1_data  <= bus.id_rs1_data;
      bus.ex_rs2_data  <= bus.id_rs2_data;
      bus.ex_imm       <= bus.id_imm;
      bus.ex_rs1       <= bus.id_rs1;
      bus.ex_rs2       <= bus.id_rs2;
      bus.ex_use_rs1   <= bus.id_use_rs1;
      bus.ex_use_rs2   <= bus.id_use_rs2;
      bus.ex_rd        <= bus.id_rd;
      bus.ex_asel      <= bus.id_asel;
      bus.ex_bsel      <= bus.id_bsel;
      bus.ex_alu_op    <= bus.id_alu_op;
      bus.ex_mem_read  <= bus.id_mem_read;
      bus.ex_mem_write <= bus.id_mem_write;
      bus.ex_reg_write <= bus.id_reg_write;
      bus.ex_wb_sel    <= bus.id_wb_sel;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.perf_stall_cnt <= '0;
      bus.perf_flush_cnt <= '0;
    end else begin
      if (lu && !bus.flush && !bus.ext_stall && !(&bus.perf_stall_cnt))
        bus.perf_stall_cnt <= bus.perf_stall_cnt + 1'b1;
      if (bus.flush && bus.id_valid && !(&bus.perf_flush_cnt))
        bus.perf_flush_cnt <= bus.perf_flush_cnt + 1'b1;
    end
  end
`else
  assign bus.perf_stall_cnt = '0;
  assign bus.perf_flush_cnt = '0;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, load-use stalls, x0, flush, freeze, load chains.
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

`ifdef ID_EX_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  id_ex_if #(.XLEN(32), .CNT_W(32)) bus ();
  id_ex_stage dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [31:0] perf_exp(input int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd, input logic u1,
                          input logic u2, input logic mr, input logic mw, input logic rw);
    bus.id_valid     = v;
    bus.id_pc        = pc;
    bus.id_rs1_data  = pc + 32'h1000;
    bus.id_rs2_data  = pc + 32'h2000;
    bus.id_imm       = pc + 32'h3000;
    bus.id_rs1       = rs1;
    bus.id_rs2       = rs2;
    bus.id_rd        = rd;
    bus.id_use_rs1   = u1;
    bus.id_use_rs2   = u2;
    bus.id_asel      = 2'd1;
    bus.id_bsel      = 2'd2;
    bus.id_alu_op    = rd[3:0];
    bus.id_mem_read  = mr;
    bus.id_mem_write = mw;
    bus.id_reg_write = rw;
    bus.id_wb_sel    = mr ? 2'd1 : 2'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.ext_stall = 1'b0;
    drive_id(1'b1, $urandom, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    drive_id(1'b1, $urandom, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    n_cmp += 6;
    if (bus.ex_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %0b want 0", bus.ex_valid); end
    if (bus.ex_rd !== 5'd0 || bus.ex_rs1 !== 5'd0 || bus.ex_rs2 !== 5'd0) begin
      n_bad++; $display("FAIL rst_idx got rd=%0d rs1=%0d rs2=%0d want 0", bus.ex_rd, bus.ex_rs1, bus.ex_rs2);
    end
    if (bus.ex_pc !== 32'd0 || bus.ex_imm !== 32'd0 || bus.ex_rs1_data !== 32'd0) begin
      n_bad++; $display("FAIL rst_data got pc=%h imm=%h want 0", bus.ex_pc, bus.ex_imm);
    end
    if (bus.ex_mem_read !== 1'b0 || bus.ex_reg_write !== 1'b0 || bus.ex_alu_op !== 4'd0) begin
      n_bad++; $display("FAIL rst_ctrl got mr=%0b rw=%0b op=%0d want 0", bus.ex_mem_read, bus.ex_reg_write, bus.ex_alu_op);
    end
    if (bus.stall_pc !== 1'b0) begin n_bad++; $display("FAIL rst_stall got %0b want 0", bus.stall_pc); end
    if (bus.perf_stall_cnt !== 32'd0 || bus.perf_flush_cnt !== 32'd0) begin
      n_bad++; $display("FAIL rst_perf got %0d/%0d want 0/0", bus.perf_stall_cnt, bus.perf_flush_cnt);
    end
    rst = 1'b0;
    drive_id(1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    $display("test_reset done: compared %0d mismatched %0d", n_cmp, n_bad);
  endtask

  task automatic test_load_use();
    drive_id(1'b1, 32'h100, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);  // lw x5
    step();
    n_cmp++;
    if (bus.ex_rd !== 5'd5 || bus.ex_mem_read !== 1'b1 || bus.ex_pc !== 32'h100) begin
      n_bad++; $display("FAIL lu_load got rd=%0d mr=%0b pc=%h want 5/1/100", bus.ex_rd, bus.ex_mem_read, bus.ex_pc);
    end
    drive_id(1'b1, 32'h104, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);  // add x6,x5,x7
    #1;
    n_cmp++;
    if (bus.stall_pc !== 1'b1 || bus.stall_ifid !== 1'b1) begin
      n_bad++; $display("FAIL lu_stall got pc=%0b ifid=%0b want 1/1", bus.stall_pc, bus.stall_ifid);
    end
    step();
    n_cmp += 2;
    if (bus.ex_valid !== 1'b0 || bus.ex_rd !== 5'd0 || bus.ex_pc !== 32'h100) begin
      n_bad++; $display("FAIL lu_bubble got v=%0b rd=%0d pc=%h want 0/0/100", bus.ex_valid, bus.ex_rd, bus.ex_pc);
    end
    if (bus.stall_pc !== 1'b0) begin n_bad++; $display("FAIL lu_release got %0b want 0", bus.stall_pc); end
    step();
    n_cmp += 2;
    if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd6 || bus.ex_pc !== 32'h104 || bus.ex_rs1_data !== 32'h1104) begin
      n_bad++; $display("FAIL lu_add got v=%0b rd=%0d pc=%h want 1/6/104", bus.ex_valid, bus.ex_rd, bus.ex_pc);
    end
    if (bus.perf_stall_cnt !== perf_exp(1)) begin
      n_bad++; $display("FAIL lu_perf got %0d want %0d", bus.perf_stall_cnt, perf_exp(1));
    end
    $display("test_load_use done: compared %0d mismatched %0d", n_cmp, n_bad);
  endtask

  task automatic test_x0();
    drive_id(1'b1, 32'h200, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);  // lw x0
    step();
    drive_id(1'b1, 32'h204, 5'd0, 5'd7, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);  // add x6,x0,x7
    #1;
    n_cmp++;
    if (bus.stall_pc !== 1'b0) begin n_bad++; $display("FAIL x0_stall got %0b want 0", bus.stall_pc); end
    step();
    n_cmp++;
    if (bus.ex_rd !== 5'd6 || bus.ex_pc !== 32'h204) begin
      n_bad++; $display("FAIL x0_add got rd=%0d pc=%h want 6/204", bus.ex_rd, bus.ex_pc);
    end
    $display("test_x0 done: compared %0d mismatched %0d", n_cmp, n_bad);
  endtask

  task automatic test_flush();
    drive_id(1'b1, 32'h300, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);  // lw x5
    step();
    drive_id(1'b1, 32'h304, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);  // sw x5,0(x5)
    bus.flush = 1'b1;
    #1;
    n_cmp++;
    if (bus.stall_pc !== 1'b0) begin n_bad++; $display("FAIL fl_stall got %0b want 0", bus.stall_pc); end
    step();
    bus.flush = 1'b0;
    drive_id(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp += 2;
    if (bus.ex_valid !== 1'b0 || bus.ex_mem_write !== 1'b0 || bus.ex_rd !== 5'd0 || bus.ex_pc !== 32'h300) begin
      n_bad++; $display("FAIL fl_bubble got v=%0b mw=%0b rd=%0d pc=%h want 0/0/0/300", bus.ex_valid, bus.ex_mem_write, bus.ex_rd, bus.ex_pc);
    end
    if (bus.perf_flush_cnt !== perf_exp(1) || bus.perf_stall_cnt !== perf_exp(1)) begin
      n_bad++; $display("FAIL fl_perf got flush=%0d stall=%0d want %0d/%0d", bus.perf_flush_cnt, bus.perf_stall_cnt, perf_exp(1), perf_exp(1));
    end
    $display("test_flush done: compared %0d mismatched %0d", n_cmp, n_bad);
  endtask

  task automatic test_ext_stall();
    drive_id(1'b1, 32'h400, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);  // add x6
    step();
    drive_id(1'b1, 32'h404, 5'd1, 5'd2, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);  // sub x8
    bus.ext_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (bus.stall_pc !== 1'b1 || bus.stall_ifid !== 1'b1) begin
        n_bad++; $display("FAIL es_stall[%0d] got %0b/%0b want 1/1", i, bus.stall_pc, bus.stall_ifid);
      end
      step();
      n_cmp++;
      if (bus.ex_rd !== 5'd6 || bus.ex_pc !== 32'h400 || bus.ex_valid !== 1'b1 || bus.ex_imm !== 32'h3400) begin
        n_bad++; $display("FAIL es_hold[%0d] got rd=%0d pc=%h want 6/400", i, bus.ex_rd, bus.ex_pc);
      end
    end
    bus.ext_stall = 1'b0;
    #1;
    n_cmp++;
    if (bus.stall_pc !== 1'b0) begin n_bad++; $display("FAIL es_release got %0b want 0", bus.stall_pc); end
    step();
    n_cmp++;
    if (bus.ex_rd !== 5'd8 || bus.ex_pc !== 32'h404) begin
      n_bad++; $display("FAIL es_next got rd=%0d pc=%h want 8/404", bus.ex_rd, bus.ex_pc);
    end
    $display("test_ext_stall done: compared %0d mismatched %0d", n_cmp, n_bad);
  endtask

  task automatic test_back_to_back();
    int stalls = 0;
    logic [4:0] seen_rd[$];
    drive_id(1'b1, 32'h500, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);  // lw x1
    #1;
    if (bus.stall_pc) stalls++;
    step();
    if (bus.ex_valid) seen_rd.push_back(bus.ex_rd);
    drive_id(1'b1, 32'h504, 5'd1, 5'd0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);  // lw x2,0(x1)
    for (int i = 0; i < 2; i++) begin
      #1;
      if (bus.stall_pc) stalls++;
      step();
      if (bus.ex_valid) seen_rd.push_back(bus.ex_rd);
    end
    drive_id(1'b1, 32'h508, 5'd2, 5'd1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);  // add x3,x2,x1
    for (int i = 0; i < 2; i++) begin
      #1;
      if (bus.stall_pc) stalls++;
      step();
      if (bus.ex_valid) seen_rd.push_back(bus.ex_rd);
    end
    n_cmp += 3;
    if (stalls != 2) begin n_bad++; $display("FAIL b2b_stalls got %0d want 2", stalls); end
    if (seen_rd.size() != 3 || seen_rd[0] !== 5'd1 || seen_rd[1] !== 5'd2 || seen_rd[2] !== 5'd3) begin
      n_bad++; $display("FAIL b2b_order got n=%0d want x1,x2,x3", seen_rd.size());
    end
    if (bus.perf_stall_cnt !== perf_exp(3)) begin
      n_bad++; $display("FAIL b2b_perf got %0d want %0d", bus.perf_stall_cnt, perf_exp(3));
    end
    $display("test_back_to_back done: compared %0d mismatched %0d", n_cmp, n_bad);
  endtask

  task automatic test_reset_mid_stall();
    drive_id(1'b1, 32'h600, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);  // lw x9
    step();
    drive_id(1'b1, 32'h604, 5'd3, 5'd9, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);  // uses x9 via rs2
    #1;
    n_cmp++;
    if (bus.stall_pc !== 1'b1) begin n_bad++; $display("FAIL rms_pre got %0b want 1", bus.stall_pc); end
    rst = 1'b1;
    step();
    n_cmp += 2;
    if (bus.stall_pc !== 1'b0 || bus.ex_valid !== 1'b0) begin
      n_bad++; $display("FAIL rms_post got stall=%0b v=%0b want 0/0", bus.stall_pc, bus.ex_valid);
    end
    if (bus.perf_stall_cnt !== 32'd0 || bus.perf_flush_cnt !== 32'd0) begin
      n_bad++; $display("FAIL rms_perf got %0d/%0d want 0/0", bus.perf_stall_cnt, bus.perf_flush_cnt);
    end
    rst = 1'b0;
    $display("test_reset_mid_stall done: compared %0d mismatched %0d", n_cmp, n_bad);
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_x0();
    test_flush();
    test_ext_stall();
    test_back_to_back();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
